reg_alu_pipe: RTL and testbench

REG_ALU_PIPE -- requirements
Module: reg_alu_pipe

---
 rtl/reg_alu_pkg.sv | 19 +
 rtl/reg_file_p.sv | 48 ++++
 rtl/reg_alu_pipe.sv | 137 +++++++++++++
 tb/tb_reg_alu_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_pkg.sv
// Shared types and default sizes for the register-file ALU pipeline.
// Consumers: reg_file_p, reg_alu_pipe.
package reg_alu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_NREGS  = 16;

  typedef enum logic [2:0] {
    AluZero  = 3'd0,
    AluAdd   = 3'd1,
    AluSub   = 3'd2,
    AluPassA = 3'd3,
    AluAnd   = 3'd4,
    AluOr    = 3'd5,
    AluXor   = 3'd6,
    AluInc   = 3'd7
  } alu_op_t;

endpackage

// File: rtl/reg_file_p.sv
// Register file: two asynchronous read ports, one synchronous write port, async active-high reset.
// Addresses at or above NREGS read as zero and never write.
module reg_file_p
  import reg_alu_pkg::*;
#(
  parameter  int unsigned DATA_W = DEFAULT_DATA_W,
  parameter  int unsigned NREGS  = DEFAULT_NREGS,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data
);

  // Storage is sized to the full address space so every index is legal; the
  // slots above NREGS are never written and stay at zero.
  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(NREGS);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              ra_ok;
  logic              rb_ok;
  logic              w_ok;

  assign ra_ok = {1'b0, ra_addr} < LIMIT;
  assign rb_ok = {1'b0, rb_addr} < LIMIT;
  assign w_ok  = {1'b0, w_addr} < LIMIT;

  assign ra_data = ra_ok ? regs[ra_addr] : '0;
  assign rb_data = rb_ok ? regs[rb_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (w_en && w_ok) begin
      regs[w_addr] <= w_data;
    end
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage (RD/EX) register-file ALU pipeline with one-op-per-cycle throughput.
// Define REG_ALU_BYPASS_EN to forward EX results into RD; otherwise RAW hazards stall one cycle.
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter  int unsigned DATA_W = DEFAULT_DATA_W,
  parameter  int unsigned NREGS  = DEFAULT_NREGS,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        ALU_s0,
  input  logic [ADDR_W-1:0] RF_Ra_Addr,
  input  logic [ADDR_W-1:0] RF_Rb_Addr,
  input  logic [ADDR_W-1:0] RF_W_Addr,
  input  logic              RF_W_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic              result_valid,
  output logic              carry,
  output logic              zero
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NREGS);

  logic              rd_valid;
  logic              rd_wen;
  alu_op_t           rd_op;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [ADDR_W-1:0] rd_waddr;

  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W:0]   ex_sum;
  logic              ex_carry;
  logic              ex_write;
  logic              hit_a;
  logic              hit_b;
  logic              accept;

  reg_file_p #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (Clk),
    .rst     (Reset),
    .ra_addr (RF_Ra_Addr),
    .rb_addr (RF_Rb_Addr),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .w_en    (ex_write),
    .w_addr  (rd_waddr),
    .w_data  (ex_result)
  );

  // Only an in-range write can create a hazard; out-of-range reads are zero anyway.
  assign ex_write = rd_valid && rd_wen && ({1'b0, rd_waddr} < LIMIT);
  assign hit_a    = ex_write && (RF_Ra_Addr == rd_waddr);
  assign hit_b    = ex_write && (RF_Rb_Addr == rd_waddr);

`ifdef REG_ALU_BYPASS_EN
  assign op_ready = 1'b1;
  assign op_a     = hit_a ? ex_result : rf_a;
  assign op_b     = hit_b ? ex_result : rf_b;
`else
  // The held request is taken next cycle, once the write has landed in the RF.
  assign op_ready = !(op_valid && (hit_a || hit_b));
  assign op_a     = rf_a;
  assign op_b     = rf_b;
`endif

  assign accept = op_valid && op_ready;

  always_comb begin
    ex_sum    = '0;
    ex_result = '0;
    ex_carry  = 1'b0;
    case (rd_op)
      AluAdd: begin
        ex_sum    = {1'b0, rd_a} + {1'b0, rd_b};
        ex_result = ex_sum[DATA_W-1:0];
        ex_carry  = ex_sum[DATA_W];
      end
      AluSub: begin
        ex_sum    = {1'b0, rd_a} - {1'b0, rd_b};
        ex_result = ex_sum[DATA_W-1:0];
        ex_carry  = ~ex_sum[DATA_W]; // carry is NOT borrow
      end
      AluPassA: ex_result = rd_a;
      AluAnd:   ex_result = rd_a & rd_b;
      AluOr:    ex_result = rd_a | rd_b;
      AluXor:   ex_result = rd_a ^ rd_b;
      AluInc: begin
        ex_sum    = {1'b0, rd_a} + {{DATA_W{1'b0}}, 1'b1};
        ex_result = ex_sum[DATA_W-1:0];
        ex_carry  = ex_sum[DATA_W];
      end
      default: ex_result = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_valid     <= 1'b0;
      rd_wen       <= 1'b0;
      rd_op        <= AluZero;
      rd_a         <= '0;
      rd_b         <= '0;
      rd_waddr     <= '0;
      ALU_result   <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      rd_valid     <= accept;
      result_valid <= rd_valid;
      if (accept) begin
        rd_op    <= alu_op_t'(ALU_s0);
        rd_a     <= op_a;
        rd_b     <= op_b;
        rd_waddr <= RF_W_Addr;
        rd_wen   <= RF_W_en;
      end
      if (rd_valid) begin
        ALU_result <= ex_result;
        carry      <= ex_carry;
        zero       <= (ex_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: directed cases with literal expectations plus random ops checked
// every cycle against an architectural model (honours REG_ALU_BYPASS_EN).
module tb_reg_alu_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 12;
  localparam int unsigned AW = $clog2(NR);
  localparam longint unsigned MOD = 64'd1 << DW;
`ifdef REG_ALU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    ALU_s0;
  logic [AW-1:0] RF_Ra_Addr;
  logic [AW-1:0] RF_Rb_Addr;
  logic [AW-1:0] RF_W_Addr;
  logic          RF_W_en;
  logic [DW-1:0] ALU_result;
  logic          result_valid;
  logic          carry;
  logic          zero;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_count = 0;
  int stalls = 0;

  reg_alu_pipe #(
    .DATA_W (DW),
    .NREGS  (NR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .ALU_s0       (ALU_s0),
    .RF_Ra_Addr   (RF_Ra_Addr),
    .RF_Rb_Addr   (RF_Rb_Addr),
    .RF_W_Addr    (RF_W_Addr),
    .RF_W_en      (RF_W_en),
    .ALU_result   (ALU_result),
    .result_valid (result_valid),
    .carry        (carry),
    .zero         (zero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural ALU: what the op means, in plain integer arithmetic.
  function automatic void model_alu(input int op, input int unsigned a, input int unsigned b,
                                    output int unsigned r, output bit c);
    longint unsigned full;
    c = 1'b0;
    case (op)
      1: begin full = longint'(a) + longint'(b); c = (full >= MOD); end
      2: begin full = longint'(a) + MOD - longint'(b); c = (a >= b); end
      3: full = a;
      4: full = a & b;
      5: full = a | b;
      6: full = a ^ b;
      7: begin full = longint'(a) + 1; c = (full >= MOD); end
      default: full = 0;
    endcase
    r = int'(full % MOD);
  endfunction

  // Model: each accepted op executes on the architectural registers at its accept edge
  // (so later ops see earlier writes); its outputs show up one edge later.
  initial begin : compare
    int unsigned mregs [NR];
    bit          pend_valid, pend_wen, pend_c, exp_valid, exp_c, exp_z, exp_ready, acc;
    int unsigned pend_res, exp_res, a, b, r;
    int          pend_w, ra, rb, w;
    bit          c;
    pend_valid = 0; pend_wen = 0; pend_c = 0; pend_res = 0; pend_w = 0;
    exp_valid = 0; exp_c = 0; exp_z = 0; exp_res = 0;
    foreach (mregs[i]) mregs[i] = 0;
    forever begin
      @(negedge Clk);
      #3;
      if (Reset) begin
        foreach (mregs[i]) mregs[i] = 0;
        pend_valid = 0; exp_valid = 0; exp_res = 0; exp_c = 0; exp_z = 0;
      end else begin
        ra = int'(RF_Ra_Addr); rb = int'(RF_Rb_Addr); w = int'(RF_W_Addr);
        exp_ready = BYPASS || !(op_valid && pend_valid && pend_wen && pend_w < NR &&
                                (ra == pend_w || rb == pend_w));
        chk("op_ready", op_ready, exp_ready);
        acc = op_valid && exp_ready;
        exp_valid = pend_valid;
        if (pend_valid) begin
          exp_res = pend_res; exp_c = pend_c; exp_z = (pend_res == 0);
        end
        pend_valid = acc;
        if (acc) begin
          a = (ra < NR) ? mregs[ra] : 0;
          b = (rb < NR) ? mregs[rb] : 0;
          model_alu(int'(ALU_s0), a, b, r, c);
          if (RF_W_en && w < NR) mregs[w] = r;
          pend_res = r; pend_c = c; pend_w = w; pend_wen = RF_W_en;
        end
      end
      @(posedge Clk);
      #1;
      chk("result_valid", result_valid, exp_valid);
      chk("ALU_result", ALU_result, exp_res);
      chk("carry", carry, exp_c);
      chk("zero", zero, exp_z);
      if (result_valid) rv_count++;
    end
  end

  // Presents a request and holds it until accepted; returns just after the accept edge.
  task automatic issue(input int op, input int ra, input int rb, input int w, input bit wen);
    @(negedge Clk);
    op_valid   = 1'b1;
    ALU_s0     = 3'(op);
    RF_Ra_Addr = AW'(ra);
    RF_Rb_Addr = AW'(rb);
    RF_W_Addr  = AW'(w);
    RF_W_en    = wen;
    for (int t = 0; t < 4; t++) begin
      #3;
      if (op_ready) begin
        @(posedge Clk);
        return;
      end
      stalls++;
      @(negedge Clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL issue_timeout: op_ready stayed 0, required 1 within 4 cycles");
    op_valid = 1'b0;
  endtask

  // Drops op_valid and waits until the last accepted op's result is visible.
  task automatic settle();
    @(negedge Clk);
    op_valid = 1'b0;
    @(posedge Clk);
    #2;
  endtask

  initial begin : stim
    int rv0;
    Reset = 1'b1; op_valid = 1'b0; ALU_s0 = '0; RF_W_en = 1'b0;
    RF_Ra_Addr = '0; RF_Rb_Addr = '0; RF_W_Addr = '0;
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_result", ALU_result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_flags", {carry, zero}, 0);
    @(negedge Clk);
    Reset = 1'b0;
    #3;
    chk("ready_after_rst", op_ready, 1);

    // Zero op into R0 and R1: two pulses, zero flag set.
    rv0 = rv_count;
    issue(0, 1, 1, 0, 1);
    issue(0, 2, 2, 1, 1);
    settle();
    chk("op0_result", ALU_result, 0);
    chk("op0_zero", zero, 1);
    chk("op0_pulses", rv_count - rv0, 2);

    // Back-to-back increments of R0 through the hazard.
    stalls = 0;
    issue(7, 0, 0, 0, 1);
    issue(7, 0, 0, 0, 1);
    settle();
    chk("inc_twice", ALU_result, 2);
    chk("inc_stalls", stalls, BYPASS ? 0 : 1);

    // R1=1, then R2=R0+R1=3 and R2=R2-R0=1 back to back.
    issue(7, 1, 1, 1, 1);
    settle();
    chk("r1_set", ALU_result, 1);
    issue(1, 0, 1, 2, 1);
    issue(2, 2, 0, 2, 1);
    settle();
    chk("sub_result", ALU_result, 1);
    chk("sub_no_borrow", carry, 1);

    // 0-1 wraps to 0xFFFF with borrow, then 0xFFFF+1 wraps to 0 with carry.
    issue(2, 3, 1, 0, 1);
    settle();
    chk("wrap_sub", ALU_result, 16'hFFFF);
    chk("wrap_sub_c", carry, 0);
    issue(7, 0, 0, 4, 1);
    settle();
    chk("wrap_inc", ALU_result, 0);
    chk("wrap_inc_cz", {carry, zero}, 2'b11);

    // Out-of-range write is dropped and does not look like a hazard.
    stalls = 0;
    issue(7, 1, 1, 13, 1);
    issue(3, 13, 13, 5, 1);
    settle();
    chk("oor_read", ALU_result, 0);
    chk("oor_stalls", stalls, 0);
    issue(3, 1, 1, 6, 0);
    settle();
    chk("r1_intact", ALU_result, 1);

    // Reset between accept and write-back: nothing completes.
    issue(7, 1, 1, 1, 1);
    @(negedge Clk);
    op_valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #2;
    chk("midrst_valid", result_valid, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #2;
    chk("midrst_valid2", result_valid, 0);
    issue(3, 1, 1, 7, 0);
    settle();
    chk("midrst_r1", ALU_result, 0);

    // Random traffic with a narrow address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      int ra, rb, w;
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      rb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      w  = ($urandom_range(0, 9) == 0) ? $urandom_range(NR, 15) : $urandom_range(0, 4);
      issue($urandom_range(0, 7), ra, rb, w, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge Clk);
        op_valid = 1'b0;
        @(posedge Clk);
      end
    end
    settle();
    repeat (3) @(posedge Clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
